// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and helpers for VGA timing generators.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_PULSE  = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_PULSE  = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_BITS_X   = 10;
  localparam int VGA_BITS_Y   = 10;
  localparam bit VGA_SYNC_POL = 1'b0;

  function automatic int timing_total(input int active, input int front,
                                      input int pulse, input int back);
    return active + front + pulse + back;
  endfunction

endpackage

// File: rtl/vga_video_timing_if.sv
// Bundle of the pixel-advance enable and the registered video timing outputs.
interface vga_video_timing_if #(
  parameter int C_bits_x = 10,
  parameter int C_bits_y = 10
);
  logic                clken;
  logic [C_bits_x-1:0] x;
  logic [C_bits_y-1:0] y;
  logic                hsync;
  logic                vsync;
  logic                blank;
  logic                line_start;
  logic                frame_start;

  modport master (input clken, output x, y, hsync, vsync, blank, line_start, frame_start);
  modport slave  (output clken, input x, y, hsync, vsync, blank, line_start, frame_start);
endinterface

// File: rtl/vga_timing_axis.sv
// One timing axis: wrapping counter plus sync-pulse and visible-window decode.
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int C_active   = VGA_H_ACTIVE,
  parameter int C_front    = VGA_H_FRONT,
  parameter int C_pulse    = VGA_H_PULSE,
  parameter int C_back     = VGA_H_BACK,
  parameter bit C_polarity = VGA_SYNC_POL,
  parameter int C_bits     = VGA_BITS_X
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output logic [C_bits-1:0] count_o,
  output logic              wrap_o,
  output logic              active_d_o,
  output logic              sync_o
);

  localparam int              C_total   = timing_total(C_active, C_front, C_pulse, C_back);
  localparam logic [C_bits-1:0] C_last  = C_bits'(C_total - 1);
  // Window bounds carry one extra bit so an end bound equal to the total still fits.
  localparam logic [C_bits:0] C_act_w   = (C_bits+1)'(C_active);
  localparam logic [C_bits:0] C_sync_lo = (C_bits+1)'(C_active + C_front);
  localparam logic [C_bits:0] C_sync_hi = (C_bits+1)'(C_active + C_front + C_pulse);

  logic [C_bits-1:0] count_q, count_d;
  logic [C_bits:0]   count_ext;
  logic              sync_q, sync_d;

  assign wrap_o = en_i && (count_q == C_last);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == C_last) ? '0 : count_q + 1'b1;
    end
  end

  // Decode from the next-state count so the registered flags line up with count_q.
  assign count_ext  = {1'b0, count_d};
  assign active_d_o = (count_ext < C_act_w);
  assign sync_d     = (count_ext >= C_sync_lo && count_ext < C_sync_hi) ? C_polarity : ~C_polarity;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= C_last;
      sync_q  <= ~C_polarity;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/vga_video_timing.sv
// VGA raster timing generator: x/y counters, sync pulses, blanking and start strobes.
module vga_video_timing
  import vga_timing_pkg::*;
#(
  parameter int C_resolution_x      = VGA_H_ACTIVE,
  parameter int C_hsync_front_porch = VGA_H_FRONT,
  parameter int C_hsync_pulse       = VGA_H_PULSE,
  parameter int C_hsync_back_porch  = VGA_H_BACK,
  parameter int C_resolution_y      = VGA_V_ACTIVE,
  parameter int C_vsync_front_porch = VGA_V_FRONT,
  parameter int C_vsync_pulse       = VGA_V_PULSE,
  parameter int C_vsync_back_porch  = VGA_V_BACK,
  parameter bit C_hsync_polarity    = VGA_SYNC_POL,
  parameter bit C_vsync_polarity    = VGA_SYNC_POL,
  parameter int C_bits_x            = VGA_BITS_X,
  parameter int C_bits_y            = VGA_BITS_Y
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                clken,
  output logic [C_bits_x-1:0] x,
  output logic [C_bits_y-1:0] y,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                line_start,
  output logic                frame_start
);

  localparam int C_h_total = timing_total(C_resolution_x, C_hsync_front_porch,
                                          C_hsync_pulse, C_hsync_back_porch);
  localparam int C_v_total = timing_total(C_resolution_y, C_vsync_front_porch,
                                          C_vsync_pulse, C_vsync_back_porch);

  if (C_h_total - 1 >= (1 << C_bits_x)) begin : g_bad_bits_x
    $error("vga_video_timing: H_total-1 does not fit in C_bits_x");
  end
  if (C_v_total - 1 >= (1 << C_bits_y)) begin : g_bad_bits_y
    $error("vga_video_timing: V_total-1 does not fit in C_bits_y");
  end

  logic x_wrap, y_wrap, x_active_d, y_active_d;
  logic blank_q, line_start_q, frame_start_q;

  vga_timing_axis #(
    .C_active  (C_resolution_x),
    .C_front   (C_hsync_front_porch),
    .C_pulse   (C_hsync_pulse),
    .C_back    (C_hsync_back_porch),
    .C_polarity(C_hsync_polarity),
    .C_bits    (C_bits_x)
  ) u_axis_x (
    .clk       (clk_pixel),
    .reset     (reset),
    .en_i      (clken),
    .count_o   (x),
    .wrap_o    (x_wrap),
    .active_d_o(x_active_d),
    .sync_o    (hsync)
  );

  // The vertical axis only steps when the horizontal axis wraps.
  vga_timing_axis #(
    .C_active  (C_resolution_y),
    .C_front   (C_vsync_front_porch),
    .C_pulse   (C_vsync_pulse),
    .C_back    (C_vsync_back_porch),
    .C_polarity(C_vsync_polarity),
    .C_bits    (C_bits_y)
  ) u_axis_y (
    .clk       (clk_pixel),
    .reset     (reset),
    .en_i      (x_wrap),
    .count_o   (y),
    .wrap_o    (y_wrap),
    .active_d_o(y_active_d),
    .sync_o    (vsync)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= ~(x_active_d && y_active_d);
      line_start_q  <= x_wrap;
      frame_start_q <= x_wrap && y_wrap;
    end
  end

  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_video_timing.sv
// Bench for vga_video_timing: default, reduced and inverted-polarity instances against a model.
module tb_vga_video_timing;

  typedef struct {
    int x; int y;
    bit hs; bit vs; bit bl; bit ls; bit fs;
  } vid_t;

  typedef struct {
    int ha; int hf; int hp; int hb;
    int va; int vf; int vp; int vb;
    bit hpol; bit vpol;
  } cfg_t;

  logic clk;
  logic reset;

  vga_video_timing_if #(.C_bits_x(10), .C_bits_y(10)) vif_def ();
  vga_video_timing_if #(.C_bits_x(5),  .C_bits_y(5))  vif_sml ();
  vga_video_timing_if #(.C_bits_x(5),  .C_bits_y(5))  vif_inv ();

  vga_video_timing dut_def (
    .clk_pixel(clk), .reset(reset), .clken(vif_def.clken),
    .x(vif_def.x), .y(vif_def.y), .hsync(vif_def.hsync), .vsync(vif_def.vsync),
    .blank(vif_def.blank), .line_start(vif_def.line_start), .frame_start(vif_def.frame_start)
  );

  vga_video_timing #(
    .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
    .C_resolution_y(6), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(2),
    .C_hsync_polarity(1'b0), .C_vsync_polarity(1'b0), .C_bits_x(5), .C_bits_y(5)
  ) dut_sml (
    .clk_pixel(clk), .reset(reset), .clken(vif_sml.clken),
    .x(vif_sml.x), .y(vif_sml.y), .hsync(vif_sml.hsync), .vsync(vif_sml.vsync),
    .blank(vif_sml.blank), .line_start(vif_sml.line_start), .frame_start(vif_sml.frame_start)
  );

  vga_video_timing #(
    .C_resolution_x(8), .C_hsync_front_porch(2), .C_hsync_pulse(3), .C_hsync_back_porch(3),
    .C_resolution_y(6), .C_vsync_front_porch(1), .C_vsync_pulse(2), .C_vsync_back_porch(2),
    .C_hsync_polarity(1'b1), .C_vsync_polarity(1'b1), .C_bits_x(5), .C_bits_y(5)
  ) dut_inv (
    .clk_pixel(clk), .reset(reset), .clken(vif_inv.clken),
    .x(vif_inv.x), .y(vif_inv.y), .hsync(vif_inv.hsync), .vsync(vif_inv.vsync),
    .blank(vif_inv.blank), .line_start(vif_inv.line_start), .frame_start(vif_inv.frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  cfg_t cfg [3];
  int mx [3];
  int my [3];
  vid_t q_def [$];
  vid_t q_sml [$];
  vid_t q_inv [$];
  string dut_name [3] = '{"def", "sml", "inv"};

  int  cyc = 0;
  bit  meas_en = 0;
  int  hs_cnt = 0;
  int  bl_cnt = 0;
  int  last_ls [3];
  int  last_fs [3];
  int  ls_per [3];
  int  fs_per [3];

  task automatic check_val(input string tag, input int obs, input int exp);
    compare_cnt++;
    if (obs != exp) begin
      mismatch_cnt++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input bit en, input bit rst);
    vid_t e;
    int ht;
    int vt;
    cfg_t c;
    c  = cfg[d];
    ht = c.ha + c.hf + c.hp + c.hb;
    vt = c.va + c.vf + c.vp + c.vb;
    e.ls = 0;
    e.fs = 0;
    if (rst) begin
      mx[d] = ht - 1;
      my[d] = vt - 1;
    end else if (en) begin
      if (mx[d] == ht - 1) begin
        e.ls = 1;
        if (my[d] == vt - 1) e.fs = 1;
        my[d] = (my[d] + 1) % vt;
      end
      mx[d] = (mx[d] + 1) % ht;
    end
    e.x = mx[d];
    e.y = my[d];
    if (rst) begin
      e.hs = !c.hpol;
      e.vs = !c.vpol;
      e.bl = 1;
    end else begin
      e.hs = (mx[d] >= c.ha + c.hf && mx[d] < c.ha + c.hf + c.hp) ? c.hpol : !c.hpol;
      e.vs = (my[d] >= c.va + c.vf && my[d] < c.va + c.vf + c.vp) ? c.vpol : !c.vpol;
      e.bl = !(mx[d] < c.ha && my[d] < c.va);
    end
    case (d)
      0:       q_def.push_back(e);
      1:       q_sml.push_back(e);
      default: q_inv.push_back(e);
    endcase
  endtask

  function automatic vid_t observe(input int d);
    vid_t o;
    case (d)
      0: begin
        o.x = int'(vif_def.x); o.y = int'(vif_def.y);
        o.hs = vif_def.hsync; o.vs = vif_def.vsync; o.bl = vif_def.blank;
        o.ls = vif_def.line_start; o.fs = vif_def.frame_start;
      end
      1: begin
        o.x = int'(vif_sml.x); o.y = int'(vif_sml.y);
        o.hs = vif_sml.hsync; o.vs = vif_sml.vsync; o.bl = vif_sml.blank;
        o.ls = vif_sml.line_start; o.fs = vif_sml.frame_start;
      end
      default: begin
        o.x = int'(vif_inv.x); o.y = int'(vif_inv.y);
        o.hs = vif_inv.hsync; o.vs = vif_inv.vsync; o.bl = vif_inv.blank;
        o.ls = vif_inv.line_start; o.fs = vif_inv.frame_start;
      end
    endcase
    return o;
  endfunction

  task automatic cycle(input bit en, input bit rst);
    vid_t e;
    vid_t o;
    vif_def.clken = en;
    vif_sml.clken = en;
    vif_inv.clken = en;
    reset = rst;
    for (int d = 0; d < 3; d++) model_step(d, en, rst);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       e = q_def.pop_front();
        1:       e = q_sml.pop_front();
        default: e = q_inv.pop_front();
      endcase
      o = observe(d);
      check_val({dut_name[d], ".x"}, o.x, e.x);
      check_val({dut_name[d], ".y"}, o.y, e.y);
      check_val({dut_name[d], ".hsync"}, int'(o.hs), int'(e.hs));
      check_val({dut_name[d], ".vsync"}, int'(o.vs), int'(e.vs));
      check_val({dut_name[d], ".blank"}, int'(o.bl), int'(e.bl));
      check_val({dut_name[d], ".line_start"}, int'(o.ls), int'(e.ls));
      check_val({dut_name[d], ".frame_start"}, int'(o.fs), int'(e.fs));
      if (meas_en) begin
        if (o.ls) begin
          if (last_ls[d] >= 0) ls_per[d] = cyc - last_ls[d];
          last_ls[d] = cyc;
        end
        if (o.fs) begin
          if (last_fs[d] >= 0) fs_per[d] = cyc - last_fs[d];
          last_fs[d] = cyc;
        end
        if (d == 0 && !o.hs) hs_cnt++;
        if (d == 0 && o.bl)  bl_cnt++;
      end
    end
  endtask

  task automatic report_phase(input string name);
    $display("phase %s: compared %0d, mismatched %0d", name, compare_cnt, mismatch_cnt);
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b0};
    cfg[2] = '{8, 2, 3, 3, 6, 1, 2, 2, 1'b1, 1'b1};
    for (int d = 0; d < 3; d++) begin
      mx[d] = 0; my[d] = 0;
      last_ls[d] = -1; last_fs[d] = -1;
      ls_per[d] = 0; fs_per[d] = 0;
    end

    // Reset holds regardless of clken
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    report_phase("reset");

    // Continuous run: two full lines of the default instance, many small frames
    meas_en = 1;
    for (int i = 0; i < 1700; i++) cycle(1'b1, 1'b0);
    meas_en = 0;
    check_val("def.hsync_low_cycles", hs_cnt, 192);
    check_val("def.blank_cycles", bl_cnt, 320);
    check_val("def.line_start_period", ls_per[0], 800);
    check_val("sml.line_start_period", ls_per[1], 16);
    check_val("sml.frame_start_period", fs_per[1], 176);
    check_val("inv.frame_start_period", fs_per[2], 176);
    report_phase("continuous");

    // Half-rate advance
    for (int i = 0; i < 400; i++) cycle(i[0] == 1'b0, 1'b0);
    report_phase("half_rate");

    // Mid-line reset at x=300, then release with one idle cycle first
    for (int i = 0; i < 2000; i++) begin
      if (vif_def.x == 10'd300) break;
      cycle(1'b1, 1'b0);
    end
    check_val("def.x_before_reset", int'(vif_def.x), 300);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0);
    report_phase("mid_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/vga_video_timing.md
VGA_VIDEO_TIMING -- requirements
Module: vga_video_timing

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- C_resolution_x, 640, visible pixels per line.
- C_hsync_front_porch, 16, pixels from end of visible area to hsync start.
- C_hsync_pulse, 96, hsync width in pixels.
- C_hsync_back_porch, 48, pixels from hsync end to next line.
- C_resolution_y, 480, visible lines per frame.
- C_vsync_front_porch, 10, lines.
- C_vsync_pulse, 2, lines.
- C_vsync_back_porch, 33, lines.
- C_hsync_polarity, 0, active level of hsync (0 = active low).
- C_vsync_polarity, 0, active level of vsync.
- C_bits_x, 10, width of x.
- C_bits_y, 10, width of y.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_pixel, in, 1, pixel clock; the only clock.
- reset, in, 1, synchronous, active-high.
- clken, in, 1, pixel advance enable.
- x, out, C_bits_x, horizontal counter.
- y, out, C_bits_y, vertical counter.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- blank, out, 1, high outside the visible area.
- line_start, out, 1, one-cycle strobe at x==0.
- frame_start, out, 1, one-cycle strobe at x==0 and y==0.

REQ-003 The block SHALL use one clock, clk_pixel, and a synchronous, active-high reset, reset.

Function
REQ-004 H_total = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch (default 800). V_total is the same sum over the y parameters (default 525).
REQ-005 On each clk_pixel edge with clken=1, x SHALL increment. When x==H_total-1, x SHALL wrap to 0 and y SHALL advance.
REQ-006 y SHALL increment only on an x wrap. When y==V_total-1 at an x wrap, y SHALL wrap to 0.
REQ-007 With clken=0, x, y, hsync, vsync and blank SHALL hold their values, and the strobes SHALL be 0.
REQ-008 All outputs SHALL be registered. hsync, vsync, blank and the strobes SHALL be decoded from the next-state counters, so they align exactly with x/y in the same cycle (0 cycles of skew).
REQ-009 blank SHALL be 0 if and only if x < C_resolution_x and y < C_resolution_y.
REQ-010 hsync SHALL equal C_hsync_polarity if and only if C_resolution_x+C_hsync_front_porch <= x < C_resolution_x+C_hsync_front_porch+C_hsync_pulse (default 656..751). Otherwise it SHALL be the inverse level.
REQ-011 vsync SHALL equal C_vsync_polarity if and only if C_resolution_y+C_vsync_front_porch <= y < C_resolution_y+C_vsync_front_porch+C_vsync_pulse (default 490..491), for the whole line, independent of x.
REQ-012 line_start SHALL be 1 for exactly one cycle after an enabled edge that sets x to 0. frame_start SHALL behave the same way, additionally requiring y==0.
REQ-013 Counter arithmetic SHALL be unsigned modulo the totals. H_total-1 SHALL fit in C_bits_x and V_total-1 SHALL fit in C_bits_y; a parameter violation SHALL be flagged at elaboration.

Reset
REQ-014 While reset=1, regardless of clken, outputs SHALL be: x=H_total-1, y=V_total-1, blank=1, hsync and vsync inactive, line_start=0, frame_start=0.
REQ-015 The first enabled edge after reset release SHALL produce x=0, y=0, blank=0, line_start=1, frame_start=1.
REQ-016 Reset asserted mid-frame SHALL take effect on the next edge with no partial-line artefact.

Structure
REQ-017 The 640x480@60 default timing constants SHALL live in a shared package vga_timing_pkg, for reuse by sibling top-levels and benches.
REQ-018 One sub-module, vga_timing_axis, SHALL provide a wrapping counter with sync/blank window decode. It SHALL be instantiated once for x (enabled by clken) and once for y (enabled by the x wrap).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then clken=1 -> first cycle x=0, y=0, frame_start=1, blank=0.
- One full line -> hsync=0 exactly for x=656..751 (96 cycles); blank=1 for x=640..799; line_start period 800 cycles.
- One full frame -> vsync=0 for y=490..491 only (1600 cycles); frame_start period 420000 cycles.
- clken toggling 1/0 every cycle -> sequence identical to continuous run at half rate; strobes never high while clken=0.
- Reset asserted at x=300, y=200 -> next cycle x=799, y=524, blank=1; after release, frame_start on the first enabled edge.
- C_hsync_polarity=1, C_vsync_polarity=1 -> hsync/vsync waveforms inverted, all other outputs unchanged.
